// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the execute-stage controller and mult_div_unit.
interface mult_div_unit_if;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] inputA;
    logic [31:0] inputB;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (output start, md_op, inputA, inputB, input busy, HI, LO);
    modport slave  (input start, md_op, inputA, inputB, output busy, HI, LO);
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; busy is high while a mul/div is in flight.
// Optional MADD/MSUB accumulate is enabled by defining MDU_MADD_EN.
module mult_div_unit #(
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned DIV_LAT = 10
) (
    input logic            clk,
    input logic            reset,
    mult_div_unit_if.slave md
);
    localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned CW      = $clog2(MAX_LAT + 1);

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101,
        OP_MADD  = 3'b110,
        OP_MSUB  = 3'b111
    } md_op_e;

    logic [CW-1:0]      count;
    logic [31:0]        a_q, b_q, hi_q, lo_q;
    md_op_e             op_q;
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic               res_wr;
    logic [31:0]        res_hi, res_lo;

    assign md.busy = (count != '0);
    assign md.HI   = hi_q;
    assign md.LO   = lo_q;

    // Result is formed from latched operands and only committed on the 1->0 count edge.
    always_comb begin
        prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
        prod_u = {32'h0, a_q} * {32'h0, b_q};
        res_wr = 1'b1;
        res_hi = hi_q;
        res_lo = lo_q;
        case (op_q)
            OP_MULT:  {res_hi, res_lo} = prod_s;
            OP_MULTU: {res_hi, res_lo} = prod_u;
            OP_DIV: begin
                if (b_q == '0) begin
                    res_wr = 1'b0;
                end else if (a_q == 32'h8000_0000 && b_q == '1) begin
                    res_hi = '0;
                    res_lo = 32'h8000_0000;
                end else begin
                    res_lo = $signed(a_q) / $signed(b_q);
                    res_hi = $signed(a_q) % $signed(b_q);
                end
            end
            OP_DIVU: begin
                if (b_q == '0) begin
                    res_wr = 1'b0;
                end else begin
                    res_lo = a_q / b_q;
                    res_hi = a_q % b_q;
                end
            end
`ifdef MDU_MADD_EN
            OP_MADD:  {res_hi, res_lo} = {hi_q, lo_q} + prod_s;
            OP_MSUB:  {res_hi, res_lo} = {hi_q, lo_q} - prod_s;
`endif
            default:  res_wr = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= OP_MULT;
            hi_q  <= '0;
            lo_q  <= '0;
        end else if (count != '0) begin
            count <= count - CW'(1);
            if (count == CW'(1) && res_wr) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end
        end else if (md.start) begin
            case (md_op_e'(md.md_op))
                OP_MULT, OP_MULTU: begin
                    a_q   <= md.inputA;
                    b_q   <= md.inputB;
                    op_q  <= md_op_e'(md.md_op);
                    count <= CW'(MUL_LAT);
                end
                OP_DIV, OP_DIVU: begin
                    a_q   <= md.inputA;
                    b_q   <= md.inputB;
                    op_q  <= md_op_e'(md.md_op);
                    count <= CW'(DIV_LAT);
                end
                OP_MTHI: hi_q <= md.inputA;
                OP_MTLO: lo_q <= md.inputA;
`ifdef MDU_MADD_EN
                OP_MADD, OP_MSUB: begin
                    a_q   <= md.inputA;
                    b_q   <= md.inputB;
                    op_q  <= md_op_e'(md.md_op);
                    count <= CW'(MUL_LAT);
                end
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus random ops against a
// longint-arithmetic HI/LO model. Honours MDU_MADD_EN when defined.
module tb_mult_div_unit;
    localparam int unsigned MUL_LAT = 5;
    localparam int unsigned DIV_LAT = 10;
    localparam logic [2:0] MULT = 3'd0, MULTU = 3'd1, DIV = 3'd2, DIVU = 3'd3,
                           MTHI = 3'd4, MTLO = 3'd5, MADD = 3'd6, MSUB = 3'd7;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mult_div_unit_if mif();
    mult_div_unit #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (mif)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] m_hi = '0, m_lo = '0;

    // Reference: architectural effect of one accepted op, plus its busy length.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int lat);
        longint          sa = $signed(a);
        longint          sb = $signed(b);
        longint unsigned ua = a;
        longint unsigned ub = b;
        logic [63:0]     acc;
        lat = 0;
        case (op)
            MULT:  begin lat = MUL_LAT; {m_hi, m_lo} = sa * sb; end
            MULTU: begin lat = MUL_LAT; {m_hi, m_lo} = ua * ub; end
            DIV:   begin lat = DIV_LAT; if (b != 0) begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end end
            DIVU:  begin lat = DIV_LAT; if (b != 0) begin m_lo = 32'(ua / ub); m_hi = 32'(ua % ub); end end
            MTHI:  m_hi = a;
            MTLO:  m_lo = a;
            default: begin
`ifdef MDU_MADD_EN
                lat = MUL_LAT;
                acc = {m_hi, m_lo};
                acc = (op == MADD) ? acc + 64'(sa * sb) : acc - 64'(sa * sb);
                {m_hi, m_lo} = acc;
`endif
            end
        endcase
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        mif.start = 1'b1; mif.md_op = op; mif.inputA = a; mif.inputB = b;
        @(negedge clk);
        mif.start = 1'b0; mif.inputA = $urandom; mif.inputB = $urandom;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int cyc);
        drive(op, a, b);
        cyc = 0;
        while (mif.busy === 1'b1 && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        reset = 1'b1; mif.start = 1'b0; mif.md_op = '0; mif.inputA = '0; mif.inputB = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if (mif.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", mif.busy); end
        n_cmp++; if (mif.HI !== 32'h0) begin n_err++; $display("FAIL reset_hi: got %h want 0", mif.HI); end
        n_cmp++; if (mif.LO !== 32'h0) begin n_err++; $display("FAIL reset_lo: got %h want 0", mif.LO); end
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
    endtask

    task automatic test_mult();
        int cyc, lat;
        model(MULT, 32'hFFFF_FFFF, 32'h2, lat);
        issue(MULT, 32'hFFFF_FFFF, 32'h2, cyc);
        n_cmp++; if (cyc !== MUL_LAT) begin n_err++; $display("FAIL mult_busy: got %0d want %0d", cyc, MUL_LAT); end
        n_cmp++; if (mif.HI !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mult_hi: got %h want ffffffff", mif.HI); end
        n_cmp++; if (mif.LO !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL mult_lo: got %h want fffffffe", mif.LO); end
        model(MULTU, 32'hFFFF_FFFF, 32'h2, lat);
        issue(MULTU, 32'hFFFF_FFFF, 32'h2, cyc);
        n_cmp++; if (cyc !== MUL_LAT) begin n_err++; $display("FAIL multu_busy: got %0d want %0d", cyc, MUL_LAT); end
        n_cmp++; if (mif.HI !== 32'h1) begin n_err++; $display("FAIL multu_hi: got %h want 00000001", mif.HI); end
        n_cmp++; if (mif.LO !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL multu_lo: got %h want fffffffe", mif.LO); end
    endtask

    task automatic test_div();
        int cyc, lat;
        model(DIV, 32'hFFFF_FFF9, 32'h2, lat);
        issue(DIV, 32'hFFFF_FFF9, 32'h2, cyc);
        n_cmp++; if (cyc !== DIV_LAT) begin n_err++; $display("FAIL div_busy: got %0d want %0d", cyc, DIV_LAT); end
        n_cmp++; if (mif.LO !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_lo: got %h want fffffffd", mif.LO); end
        n_cmp++; if (mif.HI !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div_hi: got %h want ffffffff", mif.HI); end
        model(DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
        n_cmp++; if (mif.LO !== 32'h8000_0000) begin n_err++; $display("FAIL div_ovf_lo: got %h want 80000000", mif.LO); end
        n_cmp++; if (mif.HI !== 32'h0) begin n_err++; $display("FAIL div_ovf_hi: got %h want 0", mif.HI); end
        issue(MTHI, 32'h11, 32'h0, cyc); model(MTHI, 32'h11, 32'h0, lat);
        issue(MTLO, 32'h22, 32'h0, cyc); model(MTLO, 32'h22, 32'h0, lat);
        model(DIVU, 32'h7, 32'h0, lat);
        issue(DIVU, 32'h7, 32'h0, cyc);
        n_cmp++; if (cyc !== DIV_LAT) begin n_err++; $display("FAIL divz_busy: got %0d want %0d", cyc, DIV_LAT); end
        n_cmp++; if (mif.HI !== 32'h11) begin n_err++; $display("FAIL divz_hi: got %h want 00000011", mif.HI); end
        n_cmp++; if (mif.LO !== 32'h22) begin n_err++; $display("FAIL divz_lo: got %h want 00000022", mif.LO); end
    endtask

    task automatic test_move();
        int cyc, lat;
        model(MTHI, 32'h1234_5678, 32'h0, lat);
        issue(MTHI, 32'h1234_5678, 32'h0, cyc);
        n_cmp++; if (cyc !== 0) begin n_err++; $display("FAIL mthi_busy: got %0d want 0", cyc); end
        n_cmp++; if (mif.HI !== 32'h1234_5678) begin n_err++; $display("FAIL mthi_hi: got %h want 12345678", mif.HI); end
    endtask

    task automatic test_busy_ignore();
        int cyc, lat;
        model(MULT, 32'h0000_0003, 32'hFFFF_FFFB, lat);
        drive(MULT, 32'h0000_0003, 32'hFFFF_FFFB);
        cyc = 0;
        while (mif.busy === 1'b1 && cyc < 100) begin
            cyc++;
            mif.start  = (cyc <= 3);
            mif.md_op  = (cyc == 1) ? MTLO : (cyc == 2) ? DIV : MTHI;
            mif.inputA = $urandom;
            mif.inputB = $urandom | 32'h1;
            @(negedge clk);
        end
        mif.start = 1'b0;
        n_cmp++; if (cyc !== MUL_LAT) begin n_err++; $display("FAIL ign_busy: got %0d want %0d", cyc, MUL_LAT); end
        n_cmp++; if (mif.HI !== m_hi) begin n_err++; $display("FAIL ign_hi: got %h want %h", mif.HI, m_hi); end
        n_cmp++; if (mif.LO !== m_lo) begin n_err++; $display("FAIL ign_lo: got %h want %h", mif.LO, m_lo); end
        repeat (2) @(negedge clk);
        n_cmp++; if (mif.busy !== 1'b0) begin n_err++; $display("FAIL ign_noqueue: got %b want 0", mif.busy); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        issue(MTHI, 32'hAAAA_5555, 32'h0, cyc);
        issue(MTLO, 32'h5555_AAAA, 32'h0, cyc);
        drive(MULT, 32'hFFFF_FFFF, 32'h2);
        mif.inputA = 32'h7;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (mif.busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy: got %b want 0", mif.busy); end
        n_cmp++; if (mif.HI !== 32'h0) begin n_err++; $display("FAIL rmid_hi: got %h want 0", mif.HI); end
        n_cmp++; if (mif.LO !== 32'h0) begin n_err++; $display("FAIL rmid_lo: got %h want 0", mif.LO); end
        @(negedge clk);
        reset = 1'b0;
        repeat (MUL_LAT + 2) @(negedge clk);
        n_cmp++; if (mif.HI !== 32'h0 || mif.LO !== 32'h0) begin n_err++; $display("FAIL rmid_nowrite: got %h_%h want 0_0", mif.HI, mif.LO); end
        n_cmp++; if (mif.busy !== 1'b0) begin n_err++; $display("FAIL rmid_idle: got %b want 0", mif.busy); end
        m_hi = '0; m_lo = '0;
    endtask

    task automatic test_madd();
        int cyc, lat;
        issue(MTHI, 32'h0, 32'h0, cyc); model(MTHI, 32'h0, 32'h0, lat);
        issue(MTLO, 32'hFFFF_FFFF, 32'h0, cyc); model(MTLO, 32'hFFFF_FFFF, 32'h0, lat);
        model(MADD, 32'h1, 32'h1, lat);
        issue(MADD, 32'h1, 32'h1, cyc);
`ifdef MDU_MADD_EN
        n_cmp++; if (cyc !== MUL_LAT) begin n_err++; $display("FAIL madd_busy: got %0d want %0d", cyc, MUL_LAT); end
        n_cmp++; if (mif.HI !== 32'h1) begin n_err++; $display("FAIL madd_hi: got %h want 00000001", mif.HI); end
        n_cmp++; if (mif.LO !== 32'h0) begin n_err++; $display("FAIL madd_lo: got %h want 0", mif.LO); end
`else
        n_cmp++; if (cyc !== 0) begin n_err++; $display("FAIL madd_busy: got %0d want 0", cyc); end
        n_cmp++; if (mif.HI !== 32'h0) begin n_err++; $display("FAIL madd_hi: got %h want 0", mif.HI); end
        n_cmp++; if (mif.LO !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL madd_lo: got %h want ffffffff", mif.LO); end
`endif
    endtask

    task automatic test_random();
        int cyc, lat;
        logic [2:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            model(op, a, b, lat);
            issue(op, a, b, cyc);
            n_cmp++; if (cyc !== lat) begin n_err++; $display("FAIL rnd_busy[%0d] op=%0d: got %0d want %0d", i, op, cyc, lat); end
            n_cmp++; if (mif.HI !== m_hi || mif.LO !== m_lo) begin
                n_err++; $display("FAIL rnd_hilo[%0d] op=%0d a=%h b=%h: got %h_%h want %h_%h", i, op, a, b, mif.HI, mif.LO, m_hi, m_lo);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_move();
        test_busy_ignore();
        test_reset_mid();
        test_madd();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide unit in the execute stage, beside the ALU, driven by the same two operands (inputA = rs, inputB = rt).
- Owns the HI/LO architectural registers for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Exposes HI/LO for MFHI/MFLO, which merge into the ALU result path.
- Raises busy so the controller stalls dependent HI/LO accesses.

Parameters:
- MUL_LAT, 5, busy cycles for MULT/MULTU (must be ≥1).
- DIV_LAT, 10, busy cycles for DIV/DIVU (must be ≥1).

Ports:
- clk, input, 1, system clock, rising edge.
- reset, input, 1, asynchronous active-high reset.
- start, input, 1, one-cycle request strobe, sampled on rising clk.
- md_op, input, 3, operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MADD, 111 MSUB.
- inputA, input, 32, rs operand.
- inputB, input, 32, rt operand.
- busy, output, 1, high while a multiply or divide is in flight.
- HI, output, 32, HI register.
- LO, output, 32, LO register.

Behaviour:
- Reset (async, any time, including mid-operation):
  - HI=0, LO=0, busy=0, internal count=0, latched operands/op cleared.
  - No pending result is ever written after reset.
- Idle, start=1, md_op is MULT/MULTU/DIV/DIVU:
  - Latch inputA, inputB and md_op at that edge.
  - Load count with MUL_LAT or DIV_LAT.
  - busy=1 from the next cycle.
- Counter operation:
  - busy = (count != 0), driven directly from the register.
  - count decrements every cycle while nonzero.
  - On the edge where count goes 1→0, write HI/LO from the latched operands.
  - Result is visible the same cycle busy falls, so busy is high for exactly MUL_LAT or DIV_LAT cycles.
- Idle, start=1, MTHI/MTLO:
  - HI (or LO) <= inputA at that edge.
  - Zero latency, busy stays 0.
- start=1 while busy:
  - Ignored for every op, including MTHI/MTLO.
  - HI/LO, count and latched operands are unchanged.
  - The controller must stall; the unit does not queue.
- start=0: no state change except counter progress.
- Arithmetic:
  - MULT: {HI,LO} = signed 32×32 → 64 product.
  - MULTU: {HI,LO} = unsigned 32×32 → 64 product.
  - DIV: LO = signed quotient, truncated toward zero; HI = remainder, with the sign of the dividend.
  - DIVU: unsigned quotient (LO) and remainder (HI).
  - Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero (inputB==0 at start):
  - Operation still runs the full DIV_LAT cycles with busy high.
  - HI/LO are left unchanged at completion.
- Operands are sampled only at start; later changes on inputA/inputB have no effect.
- md_op 110/111 without the optional feature: treated as no-op, no busy, no HI/LO change.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - 110 MADD: {HI,LO} <= {HI,LO} + signed(inputA×inputB), 64-bit wrap.
  - 111 MSUB: {HI,LO} <= {HI,LO} − signed(inputA×inputB), 64-bit wrap.
  - Both use MUL_LAT.
  - The accumulate uses HI/LO as they stand at completion. No write can occur during busy, so these are the start-time values.
- Not defined: 110/111 are no-ops as stated above. No accumulate adder is synthesised.

Test Plan:
- MULT with A=0xFFFFFFFF, B=0x00000002, start one cycle → busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- MULTU with the same operands → after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
- DIV A=0xFFFFFFF9 (−7), B=2 → busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=0 with prior HI=0x11, LO=0x22 → busy 10 cycles, HI/LO remain 0x11/0x22.
- MTHI A=0x12345678 while idle → HI=0x12345678 next edge, busy never rises. MTLO issued during an in-flight MULT → ignored, LO holds the MULT result only.
- Start MULT, change inputA mid-operation, assert reset on cycle 3 → HI=LO=0 immediately, busy=0, no write at the original completion time.
- With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, MADD A=1, B=1 → after 5 cycles HI=1, LO=0. Without the macro the same stimulus leaves HI=0, LO=0xFFFFFFFF and busy=0.
